// File: rtl/video_scanout.sv
// Raster timing generator with a line-prefetch pixel FIFO and 1x/2x/4x scaling.
// Define SCANOUT_STATUS_EN to add the per-frame saturating underflowCount output.
module video_scanout #(
  parameter int ADDR_W     = 17,
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] baseAddress,
  input  logic [1:0]        scaleMode,
  output logic              fetchRequest,
  output logic [ADDR_W-1:0] fetchAddress,
  input  logic [7:0]        fetchData,
  input  logic              fetchValid,
  output logic              hSync,
  output logic              vSync,
  output logic [7:0]        videoOutput,
  output logic              frameStart,
`ifdef SCANOUT_STATUS_EN
  output logic [15:0]       underflowCount,
`endif
  output logic              underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(H_ACTIVE + 1);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [PW:0]   C_FULL = (PW+1)'(FIFO_DEPTH);

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        sh_q, sh_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic              hs_q, hs_d, vs_q, vs_d;
  logic              fs_q, fs_d, uf_q, uf_d;
  logic [7:0]        pix_q, pix_d;

  logic              active, pop_due, frame_pt, flush, fetch_next;
  logic              empty, pop, push, accept;
  logic [HW-1:0]     smask;
  logic [VW-1:0]     nl;
  logic [31:0]       row_off;
  logic [ADDR_W-1:0] row_addr;
  logic [RW-1:0]     line_len;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  always_comb begin
    smask = '0;
    case (sh_q)
      2'd1:    smask = HW'(1);
      2'd2:    smask = HW'(3);
      default: smask = '0;
    endcase
    active     = (h_q < H_ACT) && (v_q < V_ACT);
    pop_due    = active && ((h_q & smask) == '0);
    frame_pt   = (h_q == '0) && (v_q == V_ACT);
    flush      = (h_q == H_ACT);
    nl         = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    fetch_next = flush && (nl < V_ACT);
    // Repeated source rows (S>1) are simply refetched from the same address.
    row_off    = 32'(nl >> sh_q) * (32'(H_ACTIVE) >> sh_q);
    row_addr   = base_q + ADDR_W'(row_off);
    line_len   = RW'(32'(H_ACTIVE) >> sh_q);
  end

  always_comb begin
    base_d = base_q;
    sh_d   = sh_q;
    if (frame_pt) begin
      base_d = baseAddress;
      case (scaleMode)
        2'd1:    sh_d = 2'd1;
        2'd2:    sh_d = 2'd2;
        default: sh_d = 2'd0;
      endcase
    end
  end

  always_comb begin
    empty  = (cnt_q == '0);
    pop    = pop_due && !empty;
    accept = req_q && fetchValid;
    push   = accept && !flush;
    wr_d   = wr_q + PW'(push);
    rd_d   = rd_q + PW'(pop);
    cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_comb begin
    req_d  = req_q;
    addr_d = addr_q;
    rem_d  = rem_q;
    if (flush) begin
      req_d = 1'b0;
      rem_d = fetch_next ? line_len : '0;
      if (fetch_next) addr_d = row_addr;
    end else begin
      if (accept) begin
        addr_d = addr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
      end
      if (!req_q || accept)
        req_d = (rem_d != '0) && (cnt_d < C_FULL);
    end
  end

  always_comb begin
    hs_d  = (h_q >= H_SS && h_q < H_SE) ? SYNC_POL : ~SYNC_POL;
    vs_d  = (v_q >= V_SS && v_q < V_SE) ? SYNC_POL : ~SYNC_POL;
    fs_d  = frame_pt;
    uf_d  = pop_due && empty;
    pix_d = pix_q;
    if (!active)      pix_d = 8'h00;
    else if (pop_due) pix_d = empty ? 8'h00 : mem_q[rd_q];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_q    <= '0;
      v_q    <= '0;
      base_q <= '0;
      sh_q   <= 2'd0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      req_q  <= 1'b0;
      addr_q <= '0;
      rem_q  <= '0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      fs_q   <= 1'b0;
      uf_q   <= 1'b0;
      pix_q  <= 8'h00;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      base_q <= base_d;
      sh_q   <= sh_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      req_q  <= req_d;
      addr_q <= addr_d;
      rem_q  <= rem_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fs_q   <= fs_d;
      uf_q   <= uf_d;
      pix_q  <= pix_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) mem_q[wr_q] <= fetchData;
  end

`ifdef SCANOUT_STATUS_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (fs_d)                              ucnt_d = '0;
    else if (uf_d && ucnt_q != 16'hFFFF)   ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) ucnt_q <= '0;
    else       ucnt_q <= ucnt_d;
  end

  assign underflowCount = ucnt_q;
`endif

  assign fetchRequest = req_q;
  assign fetchAddress = addr_q;
  assign hSync        = hs_q;
  assign vSync        = vs_q;
  assign videoOutput  = pix_q;
  assign frameStart   = fs_q;
  assign underflow    = uf_q;

endmodule
